// File: rtl/wb_burst_pkg.sv
// Shared Wishbone cycle/burst type constants and the read-master FSM state encoding.
package wb_burst_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_BURST,
      ST_GAP
   } state_t;
endpackage

// File: rtl/wbm_rd_fifo.sv
// First-word fall-through FIFO; exposes occupancy so the master can size bursts to free space.
module wbm_rd_fifo #(
   parameter int Dw    = 32,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [Dw-1:0] din_i,
   input  logic          pop_i,
   output logic [Dw-1:0] dout_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [Dw-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push_ok, pop_ok;

   assign pop_ok  = pop_i && (count_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push_ok = push_i && ((count_q != FULL_CNT) || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign valid_o = (count_q != '0);
   assign dout_o  = valid_o ? mem[rd_ptr_q] : '0;
   assign count_o = count_q;
endmodule

// File: rtl/wb_burst_read_master.sv
// Wishbone burst read master: streams [base, base+len) into a valid/ready port via a FWFT FIFO.
module wb_burst_read_master
   import wb_burst_pkg::*;
#(
   parameter int    Dw         = 32,
   parameter int    Aw         = 10,
   parameter int    SELw       = Dw / 8,
   parameter int    TAGw       = 3,
   parameter int    CTIw       = 3,
   parameter int    BTEw       = 2,
   parameter string BURST_MODE = "ENABLED",
   parameter int    BURST_LEN  = 4,
   parameter int    FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [Aw-1:0]   base_addr_i,
   input  logic [Aw:0]     len_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [Dw-1:0]   dout_o,
   output logic            dout_valid_o,
   input  logic            dout_ready_i,
   output logic [Aw-1:0]   m_addr_o,
   output logic [Dw-1:0]   m_dat_o,
   output logic [SELw-1:0] m_sel_o,
   output logic [TAGw-1:0] m_tag_o,
   output logic [CTIw-1:0] m_cti_o,
   output logic [BTEw-1:0] m_bte_o,
   output logic            m_stb_o,
   output logic            m_cyc_o,
   output logic            m_we_o,
   input  logic [Dw-1:0]   m_dat_i,
   input  logic            m_ack_i,
   input  logic            m_err_i,
   input  logic            m_rty_i
);
   localparam bit CLASSIC = (BURST_MODE == "DISABLED");
   localparam int RW      = Aw + 1;
   localparam int BW      = $clog2(BURST_LEN) + 1;
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;

   state_t        state_q, state_d;
   logic [Aw-1:0] addr_q, addr_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          err_q, err_d;
   logic          zdone_q, zdone_d;
   logic          push;
   logic [BW-1:0] nb;
   logic [CW-1:0] fifo_cnt, free_cnt;
   logic          in_burst, gap_done;

   wbm_rd_fifo #(.Dw(Dw), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .din_i   (m_dat_i),
      .pop_i   (dout_valid_o & dout_ready_i),
      .dout_o  (dout_o),
      .valid_o (dout_valid_o),
      .count_o (fifo_cnt)
   );

   assign free_cnt = CW'(FIFO_DEPTH) - fifo_cnt;

   always_comb begin
      nb = BW'(BURST_LEN);
      if (CLASSIC)                       nb = BW'(1);
      else if (rem_q < RW'(BURST_LEN))   nb = rem_q[BW-1:0];
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      err_d   = err_q;
      zdone_d = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               err_d = 1'b0;
               if (len_i == '0) begin
                  zdone_d = 1'b1;
               end else begin
                  addr_d  = base_addr_i;
                  rem_d   = len_i;
                  state_d = ST_ARB;
               end
            end
         end
         ST_ARB: begin
            // Only launch a burst the FIFO can fully absorb, so acks never stall.
            if (free_cnt >= CW'(nb)) begin
               beat_d  = nb;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (m_err_i) begin
               err_d   = 1'b1;
               rem_d   = '0;
               state_d = ST_GAP;
            end else if (m_rty_i) begin
               state_d = ST_GAP;
            end else if (m_ack_i) begin
               push   = 1'b1;
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               beat_d = beat_q - 1'b1;
               if (beat_q == BW'(1)) state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            state_d = (rem_q == '0) ? ST_IDLE : ST_ARB;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         zdone_q <= zdone_d;
      end
   end

   assign in_burst = (state_q == ST_BURST);
   assign gap_done = (state_q == ST_GAP) && (rem_q == '0);

   assign busy_o   = (state_q != ST_IDLE) && !gap_done;
   assign done_o   = zdone_q | gap_done;
   assign err_o    = err_q;

   assign m_cyc_o  = in_burst;
   assign m_stb_o  = in_burst;
   assign m_addr_o = addr_q;
   assign m_dat_o  = '0;
   assign m_sel_o  = {SELw{in_burst}};
   assign m_tag_o  = '0;
   assign m_bte_o  = BTEw'(BTE_LINEAR);
   assign m_we_o   = 1'b0;

   always_comb begin
      m_cti_o = '0;
      if (in_burst) begin
         if (CLASSIC)                 m_cti_o = CTIw'(CTI_CLASSIC);
         else if (beat_q == BW'(1))   m_cti_o = CTIw'(CTI_END);
         else                         m_cti_o = CTIw'(CTI_INC);
      end
   end
endmodule

// File: tb/tb_wb_burst_read_master.sv
// Directed bench: zero-wait Wishbone slave with injectable err/rty, negedge monitor, queue checks.
module tb_wb_burst_read_master;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] len = '0;
   logic        busy, done, err;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b1;
   logic [9:0]  m_addr;
   logic [31:0] m_dat_o, m_dat_i;
   logic [3:0]  m_sel;
   logic [2:0]  m_tag, m_cti;
   logic [1:0]  m_bte;
   logic        m_stb, m_cyc, m_we, m_ack, m_err, m_rty;

   always #5 clk = ~clk;

   wb_burst_read_master dut (
      .clk(clk), .reset(reset), .start_i(start), .base_addr_i(base_addr), .len_i(len),
      .busy_o(busy), .done_o(done), .err_o(err), .dout_o(dout), .dout_valid_o(dout_valid),
      .dout_ready_i(dout_ready), .m_addr_o(m_addr), .m_dat_o(m_dat_o), .m_sel_o(m_sel),
      .m_tag_o(m_tag), .m_cti_o(m_cti), .m_bte_o(m_bte), .m_stb_o(m_stb), .m_cyc_o(m_cyc),
      .m_we_o(m_we), .m_dat_i(m_dat_i), .m_ack_i(m_ack), .m_err_i(m_err), .m_rty_i(m_rty)
   );

   // Slave: always acks; err/rty injected on a chosen beat index of the current command.
   int beat_cnt = 0;
   int err_at = -1;
   int rty_at = -1;
   assign m_dat_i = 32'hC0DE_0000 | {22'd0, m_addr};
   assign m_ack   = m_stb;
   assign m_err   = m_stb && (beat_cnt == err_at);
   assign m_rty   = m_stb && (beat_cnt == rty_at);
   always @(posedge clk) begin
      if (m_stb)      beat_cnt <= beat_cnt + 1;
      else if (!busy) beat_cnt <= 0;
   end

   logic [9:0]  addr_log[$];
   logic [2:0]  cti_log[$];
   logic [31:0] data_log[$];
   logic [9:0]  exp_a[$];
   logic [2:0]  exp_c[$];
   int tcyc = 0, start_t = 0, first_stb = -1, done_t = 0, done_cnt = 0, cyc_cnt = 0;
   int n_cmp = 0, n_mis = 0;

   always @(negedge clk) begin
      tcyc++;
      if (start && !busy) start_t = tcyc;
      if (m_stb) begin
         addr_log.push_back(m_addr);
         cti_log.push_back(m_cti);
         if (first_stb < 0) first_stb = tcyc;
      end
      if (m_cyc) cyc_cnt++;
      if (done) begin done_cnt++; done_t = tcyc; end
      if (dout_valid && dout_ready) data_log.push_back(dout);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_addrs(input string tag);
      check({tag, " addr count"}, addr_log.size(), exp_a.size());
      for (int i = 0; i < exp_a.size(); i++)
         check($sformatf("%s addr[%0d]", tag, i), (i < addr_log.size()) ? addr_log[i] : 10'bx, exp_a[i]);
   endtask

   task automatic chk_ctis(input string tag);
      check({tag, " cti count"}, cti_log.size(), exp_c.size());
      for (int i = 0; i < exp_c.size(); i++)
         check($sformatf("%s cti[%0d]", tag, i), (i < cti_log.size()) ? cti_log[i] : 3'bx, exp_c[i]);
   endtask

   task automatic chk_data(input string tag, input logic [9:0] b, input int n);
      logic [9:0] a;
      check({tag, " word count"}, data_log.size(), n);
      for (int i = 0; i < n; i++) begin
         a = b + 10'(i);
         check($sformatf("%s word[%0d]", tag, i), (i < data_log.size()) ? data_log[i] : 32'bx,
               32'hC0DE_0000 | {22'd0, a});
      end
   endtask

   task automatic start_cmd(input logic [9:0] b, input logic [10:0] l);
      @(posedge clk); #1;
      addr_log.delete(); cti_log.delete(); data_log.delete();
      first_stb = -1; done_cnt = 0; cyc_cnt = 0;
      base_addr = b; len = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin @(posedge clk); n++; end
      check({tag, " done seen"}, done_cnt > 0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst busy/done/err", {busy, done, err}, 3'b000);
      check("rst stream", {dout_valid, dout}, 33'd0);
      check("rst wb ctl", {m_cyc, m_stb, m_we, m_cti, m_sel}, 10'd0);
      check("rst wb addr", m_addr, 10'd0);
      reset = 1'b1;

      // Single burst
      start_cmd(10'h010, 11'd4);
      wait_done("single", 100);
      exp_a = '{10'h010, 10'h011, 10'h012, 10'h013};
      exp_c = '{3'b010, 3'b010, 3'b010, 3'b111};
      chk_addrs("single"); chk_ctis("single"); chk_data("single", 10'h010, 4);
      check("single first stb latency", first_stb - start_t, 2);
      check("single done latency", done_t - start_t, 6);
      check("single done count", done_cnt, 1);
      check("single idle after", {busy, err, m_cyc}, 3'b000);

      // Split bursts
      start_cmd(10'h020, 11'd6);
      wait_done("split", 100);
      exp_a = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h025};
      exp_c = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b111};
      chk_addrs("split"); chk_ctis("split"); chk_data("split", 10'h020, 6);
      check("split done latency", done_t - start_t, 10);
      check("split done count", done_cnt, 1);

      // Backpressure
      dout_ready = 1'b0;
      start_cmd(10'h100, 11'd16);
      repeat (30) @(posedge clk);
      #1;
      check("bp beats before stall", addr_log.size(), 8);
      check("bp stb held low", m_stb, 1'b0);
      check("bp busy/valid", {busy, dout_valid}, 2'b11);
      check("bp no done yet", done_cnt, 0);
      dout_ready = 1'b1;
      wait_done("bp", 200);
      exp_a.delete();
      for (int i = 0; i < 16; i++) exp_a.push_back(10'h100 + 10'(i));
      chk_addrs("bp"); chk_data("bp", 10'h100, 16);
      check("bp done count", done_cnt, 1);

      // Address wrap
      start_cmd(10'h3FE, 11'd4);
      wait_done("wrap", 100);
      exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      chk_addrs("wrap"); chk_data("wrap", 10'h3FE, 4);

      // Error on beat 2 (ack also high: err must win)
      err_at = 1;
      start_cmd(10'h040, 11'd4);
      wait_done("err", 100);
      err_at = -1;
      exp_a = '{10'h040, 10'h041};
      chk_addrs("err"); chk_data("err", 10'h040, 1);
      check("err sticky", err, 1'b1);
      check("err done latency", done_t - start_t, 4);
      check("err done count", done_cnt, 1);
      check("err busy low", busy, 1'b0);

      // Retry on beat 1 (ack also high: rty must win)
      rty_at = 0;
      start_cmd(10'h050, 11'd4);
      check("rty start clears err", err, 1'b0);
      wait_done("rty", 100);
      rty_at = -1;
      exp_a = '{10'h050, 10'h050, 10'h051, 10'h052, 10'h053};
      exp_c = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
      chk_addrs("rty"); chk_ctis("rty"); chk_data("rty", 10'h050, 4);
      check("rty done latency", done_t - start_t, 9);
      check("rty err clear", err, 1'b0);

      // Zero-length command
      start_cmd(10'h070, 11'd0);
      wait_done("len0", 20);
      check("len0 no cyc", cyc_cnt, 0);
      check("len0 done latency", done_t - start_t, 1);
      check("len0 done count", done_cnt, 1);

      // Reset mid-burst
      dout_ready = 1'b0;
      start_cmd(10'h080, 11'd8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid pre-reset stb/valid", {m_stb, dout_valid}, 2'b11);
      reset = 1'b0;
      @(posedge clk); #1;
      check("mid rst busy/done/err", {busy, done, err}, 3'b000);
      check("mid rst stream", {dout_valid, dout}, 33'd0);
      check("mid rst wb ctl", {m_cyc, m_stb, m_cti, m_sel}, 9'd0);
      check("mid rst wb addr", m_addr, 10'd0);
      reset = 1'b1;
      dout_ready = 1'b1;
      @(posedge clk); #1;
      check("post rst fifo empty", {dout_valid, busy}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
